// File: rtl/addressing_unit_if.sv
// addressing_unit_if: controller-to-addressing-unit bundle (operands, one-hot selects, PC load, address).
// AddrCarry exists only when AU_CARRY_OUT_EN is defined.
interface addressing_unit_if #(
  parameter int AW = 16,
  parameter int IW = 8
);
  logic [AW-1:0] Rside;
  logic [IW-1:0] Iside;
  logic          ResetPC;
  logic          PCplusI;
  logic          PCplus1;
  logic          Iplus0;
  logic          Rplus0;
  logic          PCenable;
  logic [AW-1:0] Address;
`ifdef AU_CARRY_OUT_EN
  logic          AddrCarry;
`endif

  modport master (
    output Rside, Iside, ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable,
    input  Address
`ifdef AU_CARRY_OUT_EN
    , input AddrCarry
`endif
  );

  modport slave (
    input  Rside, Iside, ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable,
    output Address
`ifdef AU_CARRY_OUT_EN
    , output AddrCarry
`endif
  );
endinterface

// File: rtl/addressing_unit.sv
// addressing_unit: 16-bit PC plus one-hot-selected address adder; AU_CARRY_OUT_EN adds AddrCarry.
// Latency: Address is combinational from inputs and PC; PC loads on the next rising clk.
// Backpressure: none; selects and PCenable are sampled every cycle.
module addressing_unit #(
  parameter int AW = 16,
  parameter int IW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  addressing_unit_if.slave    bus
);
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_left;
  logic [AW-1:0] w_right;
  logic [AW-1:0] w_addr;

  // Priority chain: ResetPC > PCplusI > PCplus1 > Iplus0 > Rplus0 > PC+0.
  always_comb begin
    w_left  = r_pc;
    w_right = '0;
    if (bus.ResetPC) begin
      w_left  = '0;
      w_right = '0;
    end else if (bus.PCplusI) begin
      w_left  = r_pc;
      w_right = AW'($signed(bus.Iside));
    end else if (bus.PCplus1) begin
      w_left  = r_pc;
      w_right = AW'(1);
    end else if (bus.Iplus0) begin
      w_left  = '0;
      w_right = AW'(bus.Iside);
    end else if (bus.Rplus0) begin
      w_left  = bus.Rside;
      w_right = '0;
    end
  end

`ifdef AU_CARRY_OUT_EN
  logic [AW:0] w_sum;
  assign w_sum         = {1'b0, w_left} + {1'b0, w_right};
  assign w_addr        = w_sum[AW-1:0];
  assign bus.AddrCarry = w_sum[AW];
`else
  assign w_addr = w_left + w_right;
`endif

  assign bus.Address = w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (bus.ResetPC) begin
      r_pc <= '0;
    end else if (bus.PCenable) begin
      r_pc <= w_addr;
    end
  end
endmodule

// File: tb/tb_addressing_unit.sv
// tb_addressing_unit: directed plan plus randomized selects checked against a behavioural PC/address model.
module tb_addressing_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   m_pc  = 0;

  always #5 clk = ~clk;

  addressing_unit_if #(.AW(16), .IW(8)) bus ();
  addressing_unit #(.AW(16), .IW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rp, input bit pi, input bit p1, input bit i0, input bit r0,
                       input bit en, input int iside, input int rside);
    bus.ResetPC  = rp;
    bus.PCplusI  = pi;
    bus.PCplus1  = p1;
    bus.Iplus0   = i0;
    bus.Rplus0   = r0;
    bus.PCenable = en;
    bus.Iside    = 8'(iside);
    bus.Rside    = 16'(rside);
  endtask

  // Reference: plain integer sum of the selected operands, 17 bits wide.
  function automatic int model_sum();
    int l, r, iv;
    iv = int'(bus.Iside);
    l = m_pc;
    r = 0;
    if (bus.ResetPC) begin
      l = 0; r = 0;
    end else if (bus.PCplusI) begin
      l = m_pc; r = (iv >= 128) ? (iv - 256 + 65536) : iv;
    end else if (bus.PCplus1) begin
      l = m_pc; r = 1;
    end else if (bus.Iplus0) begin
      l = 0; r = iv;
    end else if (bus.Rplus0) begin
      l = int'(bus.Rside); r = 0;
    end
    return l + r;
  endfunction

  // Inputs already driven just after a falling edge; check mid-cycle, then clock once.
  task automatic step(input string tag);
    int s;
    s = model_sum();
    #1;
    check({tag, "_addr"}, 32'(bus.Address), 32'(s % 65536));
`ifdef AU_CARRY_OUT_EN
    check({tag, "_cy"}, 32'(bus.AddrCarry), 32'(s / 65536));
`endif
    @(posedge clk);
    if (rst_n) begin
      if (bus.ResetPC) m_pc = 0;
      else if (bus.PCenable) m_pc = s % 65536;
    end
    @(negedge clk);
  endtask

  task automatic check_pc(input string tag, input int exp);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check(tag, 32'(bus.Address), 32'(exp));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_low", 32'(bus.Address), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_pc("rst_pc", 16'h0000);

    drive(1, 0, 0, 0, 0, 0, 0, 0); step("rstpc");
    check_pc("rstpc_pc", 16'h0000);

    drive(0, 0, 1, 0, 0, 1, 0, 0); step("inc");
    check_pc("inc_pc", 16'h0001);
    drive(0, 0, 1, 0, 0, 0, 0, 0); #1;
    check("inc_peek", 32'(bus.Address), 32'h0002);
    @(negedge clk);
    check_pc("inc_hold", 16'h0001);

    drive(0, 1, 0, 0, 0, 1, 8'h10, 0); step("rel_fwd");
    check_pc("rel_fwd_pc", 16'h0011);
    drive(0, 1, 0, 0, 0, 1, 8'hF0, 0); step("rel_back");
    check_pc("rel_back_pc", 16'h0001);

    drive(0, 0, 0, 0, 1, 0, 0, 16'h2000); #1;
    check("rplus0", 32'(bus.Address), 32'h2000);
    @(negedge clk);
    check_pc("rplus0_pc", 16'h0001);
    drive(0, 0, 0, 1, 0, 0, 8'h30, 0); #1;
    check("iplus0", 32'(bus.Address), 32'h0030);
    drive(0, 0, 0, 1, 0, 0, 8'hFE, 0); #1;
    check("iplus0_nosx", 32'(bus.Address), 32'h00FE);
    drive(0, 1, 0, 0, 0, 0, 8'hFE, 0); #1;
    check("pci_sub", 32'(bus.Address), 32'hFFFF);
    @(negedge clk);

    drive(0, 1, 0, 0, 0, 1, 8'h10, 0); step("rel_again");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0, 1, 0, 0); step("run");
      check_pc("run_pc", 16'h0012 + k);
    end
    drive(1, 0, 0, 0, 0, 1, 0, 0); step("rst_en");
    check_pc("rst_en_pc", 16'h0000);

    drive(1, 0, 1, 0, 0, 0, 0, 0); #1;
    check("prio_rst", 32'(bus.Address), 32'h0000);
    drive(0, 1, 1, 1, 1, 0, 8'h02, 16'h4000); #1;
    check("prio_pci", 32'(bus.Address), 32'h0002);
    @(negedge clk);

    drive(0, 0, 0, 0, 1, 1, 0, 16'hFFFF); step("jump");
    check_pc("jump_pc", 16'hFFFF);
    drive(0, 0, 1, 0, 0, 0, 0, 0); #1;
    check("wrap_addr", 32'(bus.Address), 32'h0000);
`ifdef AU_CARRY_OUT_EN
    check("wrap_cy", 32'(bus.AddrCarry), 32'h1);
`endif
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 1, 0, 0); step("wrap");
    check_pc("wrap_pc", 16'h0000);

    // Asynchronous reset mid-cycle from a non-zero PC.
    drive(0, 0, 0, 0, 1, 1, 0, 16'h1234); step("pre_arst");
    check_pc("pre_arst_pc", 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(bus.Address), 32'h0000);
    m_pc = 0;
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    #1;
    check("arst_sel", 32'(bus.Address), 32'h0001);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_pc("arst_pc", 16'h0000);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)));
      step("rnd");
    end
    check_pc("final_pc", m_pc);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
